// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP capture path: FSM encoding, vsync edge helpers
// and the RGB565 colour-bar table used by the optional test pattern.
package dvp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_FS = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_SKIP    = 2'd3
    } state_t;

    localparam int SKIP_W = 4;

    // Index 0 sits at the LSB end: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][15:0] BAR_RGB565 = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

    // Frame start: vsync leaves its blanking level.
    function automatic logic is_fs(input logic vs_prev, input logic vs_cur, input logic vs_pol);
        return (vs_prev == vs_pol) && (vs_cur != vs_pol);
    endfunction

    // Frame end: vsync returns to its blanking level.
    function automatic logic is_fe(input logic vs_prev, input logic vs_cur, input logic vs_pol);
        return (vs_prev != vs_pol) && (vs_cur == vs_pol);
    endfunction

endpackage

// File: rtl/dvp_capture_win_beat_pack.sv
// Registers the raw DVP inputs once and packs bus beats into pixels, tracking
// the column of each completed pixel and flagging lines that end mid-pixel.
module dvp_beat_pack
    import dvp_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int X_W           = 12,
    parameter bit VS_POL        = 1'b1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_vsync,
    input  logic                            i_href,
    input  logic [DATA_W-1:0]               i_din,
    output logic                            o_vsync,
    output logic [DATA_W*BYTES_PER_PIX-1:0] o_pixel,
    output logic                            o_done,
    output logic [X_W-1:0]                  o_col,
    output logic                            o_line_end,
    output logic                            o_line_err
);

    localparam int PIX_W = DATA_W * BYTES_PER_PIX;

    logic              r_vsync;
    logic              r_href;
    logic              r_href_d;
    logic [DATA_W-1:0] r_din;
    logic [1:0]        r_beat;
    logic [PIX_W-1:0]  r_acc;
    logic [X_W-1:0]    r_col;
    logic [PIX_W-1:0]  r_pixel;
    logic              r_done;
    logic [X_W-1:0]    r_col_out;
    logic              r_line_end;
    logic              r_line_err;

    logic [PIX_W+DATA_W-1:0] w_cat;
    logic [PIX_W-1:0]        w_shift;
    logic                    w_last;

    // First beat ends up in the MS part after the final shift.
    assign w_cat   = {r_acc, r_din};
    assign w_shift = w_cat[PIX_W-1:0];
    assign w_last  = (r_beat == 2'(BYTES_PER_PIX - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vsync    <= ~VS_POL;
            r_href     <= 1'b0;
            r_href_d   <= 1'b0;
            r_din      <= '0;
            r_beat     <= '0;
            r_acc      <= '0;
            r_col      <= '0;
            r_pixel    <= '0;
            r_done     <= 1'b0;
            r_col_out  <= '0;
            r_line_end <= 1'b0;
            r_line_err <= 1'b0;
        end else begin
            r_vsync    <= i_vsync;
            r_href     <= i_href;
            r_din      <= i_din;
            r_href_d   <= r_href;
            r_done     <= 1'b0;
            r_line_end <= 1'b0;
            r_line_err <= 1'b0;
            if (r_href) begin
                r_acc <= w_shift;
                if (w_last) begin
                    r_pixel   <= w_shift;
                    r_done    <= 1'b1;
                    r_col_out <= r_col;
                    r_col     <= r_col + X_W'(1);
                    r_beat    <= '0;
                end else begin
                    r_beat <= r_beat + 2'd1;
                end
            end else begin
                r_beat <= '0;
                r_col  <= '0;
                if (r_href_d) begin
                    r_line_end <= 1'b1;
                    r_line_err <= (r_beat != 2'd0);
                end
            end
        end
    end

    assign o_vsync    = r_vsync;
    assign o_pixel    = r_pixel;
    assign o_done     = r_done;
    assign o_col      = r_col_out;
    assign o_line_end = r_line_end;
    assign o_line_err = r_line_err;

endmodule

// File: rtl/dvp_capture_win.sv
// DVP capture with runtime crop window and frame decimation, sop/eop framed output.
// Optional colour-bar test pattern with tp_sel input when DVP_TEST_PATTERN_EN is defined.
//
//   state      | meaning
//   IDLE       | capture disabled, waiting for cap_en
//   WAIT_FS    | armed, waiting for a frame start to latch the window
//   ACTIVE     | capturing the current frame
//   SKIP       | dropping frames until the skip counter runs out
module dvp_capture_win
    import dvp_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int X_W           = 12,
    parameter int Y_W           = 12,
    parameter bit VS_POL        = 1'b1,
    parameter int FCNT_W        = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_cap_en,
    input  logic                            i_cmos_vsync,
    input  logic                            i_cmos_href,
    input  logic [DATA_W-1:0]               i_cmos_din,
    input  logic [X_W-1:0]                  i_win_x0,
    input  logic [X_W-1:0]                  i_win_w,
    input  logic [Y_W-1:0]                  i_win_y0,
    input  logic [Y_W-1:0]                  i_win_h,
    input  logic [SKIP_W-1:0]               i_skip_n,
`ifdef DVP_TEST_PATTERN_EN
    input  logic                            i_tp_sel,
`endif
    output logic [DATA_W*BYTES_PER_PIX-1:0] o_pixel,
    output logic                            o_pixel_vld,
    output logic                            o_pixel_sop,
    output logic                            o_pixel_eop,
    output logic [FCNT_W-1:0]               o_frame_cnt,
    output logic                            o_frame_err,
    output logic                            o_line_err
);

    localparam int PIX_W = DATA_W * BYTES_PER_PIX;

    logic             w_vs;
    logic [PIX_W-1:0] w_pix;
    logic             w_done;
    logic [X_W-1:0]   w_col;
    logic             w_line_end;
    logic             w_line_err;

    dvp_beat_pack #(
        .DATA_W        (DATA_W),
        .BYTES_PER_PIX (BYTES_PER_PIX),
        .X_W           (X_W),
        .VS_POL        (VS_POL)
    ) u_beat_pack (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_vsync    (i_cmos_vsync),
        .i_href     (i_cmos_href),
        .i_din      (i_cmos_din),
        .o_vsync    (w_vs),
        .o_pixel    (w_pix),
        .o_done     (w_done),
        .o_col      (w_col),
        .o_line_end (w_line_end),
        .o_line_err (w_line_err)
    );

    state_t            r_state;
    logic              r_vs_d;
    logic [Y_W-1:0]    r_line;
    logic [X_W-1:0]    r_x0;
    logic [X_W-1:0]    r_w;
    logic [Y_W-1:0]    r_y0;
    logic [Y_W-1:0]    r_h;
    logic [SKIP_W-1:0] r_skip_lat;
    logic [SKIP_W-1:0] r_skip_cnt;
    logic              r_sop_seen;
    logic              r_eop_seen;
    logic [PIX_W-1:0]  r_pixel;
    logic              r_vld;
    logic              r_sop;
    logic              r_eop;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              r_frame_err;
    logic              r_line_err;

    logic             w_fs;
    logic             w_fe;
    logic [X_W-1:0]   w_dx;
    logic [Y_W-1:0]   w_dy;
    logic             w_in;
    logic             w_sop;
    logic             w_eop;
    logic             w_emit;
    logic             w_latch;
    logic [PIX_W-1:0] w_pix_sel;

    assign w_fs = is_fs(r_vs_d, w_vs, VS_POL);
    assign w_fe = is_fe(r_vs_d, w_vs, VS_POL);

    // Explicit lower bound keeps positions left/above the window from wrapping in.
    assign w_dx  = w_col - r_x0;
    assign w_dy  = r_line - r_y0;
    assign w_in  = (w_col >= r_x0) && (w_dx < r_w) && (r_line >= r_y0) && (w_dy < r_h);
    assign w_sop = (w_col == r_x0) && (r_line == r_y0);
    assign w_eop = (w_col == r_x0 + r_w - X_W'(1)) && (r_line == r_y0 + r_h - Y_W'(1));
    assign w_emit = w_done && w_in && (r_state == ST_ACTIVE);

    assign w_latch = i_cap_en && w_fs &&
                     ((r_state == ST_WAIT_FS) || ((r_state == ST_SKIP) && (r_skip_cnt == '0)));

`ifdef DVP_TEST_PATTERN_EN
    logic [15:0]      w_bar16;
    logic [PIX_W-1:0] w_bar;

    assign w_bar16 = BAR_RGB565[w_dx[X_W-1 -: 3]];

    always_comb begin
        w_bar = '0;
        for (int i = 0; i < PIX_W; i++) begin
            w_bar[PIX_W-1-i] = w_bar16[15 - (i % 16)];
        end
    end

    assign w_pix_sel = i_tp_sel ? w_bar : w_pix;
`else
    assign w_pix_sel = w_pix;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_vs_d      <= ~VS_POL;
            r_line      <= '0;
            r_x0        <= '0;
            r_w         <= '0;
            r_y0        <= '0;
            r_h         <= '0;
            r_skip_lat  <= '0;
            r_skip_cnt  <= '0;
            r_sop_seen  <= 1'b0;
            r_eop_seen  <= 1'b0;
            r_pixel     <= '0;
            r_vld       <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_frame_cnt <= '0;
            r_frame_err <= 1'b0;
            r_line_err  <= 1'b0;
        end else begin
            r_vs_d      <= w_vs;
            r_vld       <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_frame_err <= 1'b0;
            r_line_err  <= w_line_err;

            if (w_fs) begin
                r_line <= '0;
            end else if (w_line_end) begin
                r_line <= r_line + Y_W'(1);
            end

            if (w_done) begin
                r_pixel <= w_pix_sel;
            end

            if (w_emit) begin
                r_vld <= 1'b1;
                r_sop <= w_sop;
                r_eop <= w_eop;
                if (w_sop) r_sop_seen <= 1'b1;
                if (w_eop) begin
                    r_eop_seen  <= 1'b1;
                    r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                end
            end

            if (w_latch) begin
                r_x0       <= i_win_x0;
                r_w        <= i_win_w;
                r_y0       <= i_win_y0;
                r_h        <= i_win_h;
                r_skip_lat <= i_skip_n;
                r_sop_seen <= 1'b0;
                r_eop_seen <= 1'b0;
            end

            if (!i_cap_en) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE:    r_state <= ST_WAIT_FS;
                    ST_WAIT_FS: if (w_fs) r_state <= ST_ACTIVE;
                    ST_ACTIVE: begin
                        if (w_fe) begin
                            r_frame_err <= r_sop_seen && !r_eop_seen;
                            if (r_skip_lat == '0) begin
                                r_state <= ST_WAIT_FS;
                            end else begin
                                r_state    <= ST_SKIP;
                                r_skip_cnt <= r_skip_lat;
                            end
                        end
                    end
                    ST_SKIP: begin
                        if (w_fs) begin
                            if (r_skip_cnt == '0) r_state <= ST_ACTIVE;
                            else                  r_skip_cnt <= r_skip_cnt - SKIP_W'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_pixel     = r_pixel;
    assign o_pixel_vld = r_vld;
    assign o_pixel_sop = r_sop;
    assign o_pixel_eop = r_eop;
    assign o_frame_cnt = r_frame_cnt;
    assign o_frame_err = r_frame_err;
    assign o_line_err  = r_line_err;

endmodule

// File: tb/tb_dvp_capture_win.sv
// Scoreboard bench for dvp_capture_win: 8-column ramp frames, expected pixels
// queued at the final beat and matched (data, flags, latency) on output.
module tb_dvp_capture_win;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_en;
    logic        vsync;
    logic        href;
    logic [7:0]  din;
    logic [11:0] win_x0, win_w, win_y0, win_h;
    logic [3:0]  skip_n;
    logic        tp_sel = 1'b0;

    logic [15:0] pixel;
    logic        vld, sop, eop, ferr, lerr;
    logic [7:0]  frame_cnt;

    dvp_capture_win dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cap_en     (cap_en),
        .i_cmos_vsync (vsync),
        .i_cmos_href  (href),
        .i_cmos_din   (din),
        .i_win_x0     (win_x0),
        .i_win_w      (win_w),
        .i_win_y0     (win_y0),
        .i_win_h      (win_h),
        .i_skip_n     (skip_n),
`ifdef DVP_TEST_PATTERN_EN
        .i_tp_sel     (tp_sel),
`endif
        .o_pixel      (pixel),
        .o_pixel_vld  (vld),
        .o_pixel_sop  (sop),
        .o_pixel_eop  (eop),
        .o_frame_cnt  (frame_cnt),
        .o_frame_err  (ferr),
        .o_line_err   (lerr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] pix;
        logic        sop;
        logic        eop;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int n_chk = 0, n_fail = 0;
    int c_vld, c_sop, c_eop, c_ferr, c_lerr;
    int m_x0, m_w, m_y0, m_h;
    int fnum = 0;
    int exp_fcnt = 0;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ferr) c_ferr++;
            if (lerr) c_lerr++;
            if (vld) begin
                c_vld++;
                if (sop) c_sop++;
                if (eop) c_eop++;
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pixel got=%h sop=%b eop=%b", pixel, sop, eop);
                end else begin
                    e = sb.pop_front();
                    if (pixel !== e.pix || sop !== e.sop || eop !== e.eop) begin
                        n_fail++;
                        $display("FAIL pixel got=%h/%b/%b exp=%h/%b/%b", pixel, sop, eop, e.pix, e.sop, e.eop);
                    end
                    n_chk++;
                    if (cyc != e.at) begin
                        n_fail++;
                        $display("FAIL latency got_cycle=%0d exp_cycle=%0d", cyc, e.at);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_win(input int x0, input int w, input int y0, input int h);
        win_x0 = 12'(x0); win_w = 12'(w); win_y0 = 12'(y0); win_h = 12'(h);
        m_x0 = x0; m_w = w; m_y0 = y0; m_h = h;
    endtask

    task automatic clr_counts();
        c_vld = 0; c_sop = 0; c_eop = 0; c_ferr = 0; c_lerr = 0;
    endtask

    // One frame: ramp pixel = {frame<<4 | line, col}.
    task automatic send_frame(input int cols, input int lines, input bit cap,
                              input int err_line, input int drop_line, input int mid_skip);
        bit live;
        int nb, c;
        logic [7:0] ms;
        exp_t x;
        live = cap;
        vsync = 1'b1; tick(3);
        vsync = 1'b0; tick(4);
        for (int l = 0; l < lines; l++) begin
            if (l == drop_line) begin
                cap_en = 1'b0; tick(3);
                cap_en = 1'b1;
                live = 1'b0;
            end
            if (l == 1 && mid_skip >= 0) skip_n = 4'(mid_skip);
            ms = 8'((fnum << 4) | l);
            nb = (l == err_line) ? 5 : cols * 2;
            for (int b = 0; b < nb; b++) begin
                c = b / 2;
                href = 1'b1;
                din = (b % 2 == 0) ? ms : 8'(c);
                if ((b % 2 == 1) && live && c >= m_x0 && c < m_x0 + m_w && l >= m_y0 && l < m_y0 + m_h) begin
                    x.pix = {ms, 8'(c)};
                    x.sop = (c == m_x0) && (l == m_y0);
                    x.eop = (c == m_x0 + m_w - 1) && (l == m_y0 + m_h - 1);
                    x.at  = cyc + 3;
                    sb.push_back(x);
                end
                tick();
            end
            href = 1'b0; din = 8'h00;
            tick(4);
        end
        vsync = 1'b1; tick(4);
        fnum++;
    endtask

    task automatic test_reset();
        rst = 1'b1; cap_en = 1'b0; vsync = 1'b1; href = 1'b0; din = '0; skip_n = '0;
        set_win(0, 8, 0, 4);
        tick(3);
        n_chk++;
        if ({pixel, vld, sop, eop, frame_cnt, ferr, lerr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h/%b%b%b/%h/%b%b exp=all zero", pixel, vld, sop, eop, frame_cnt, ferr, lerr);
        end
        rst = 1'b0; tick();
        cap_en = 1'b1;
        clr_counts();
        send_frame(8, 4, 1, -1, -1, -1);
        exp_fcnt = 1;
        n_chk++; if (c_vld != 32) begin n_fail++; $display("FAIL full_vld got=%0d exp=32", c_vld); end
        n_chk++; if (c_sop != 1 || c_eop != 1) begin n_fail++; $display("FAIL full_flags sop=%0d eop=%0d exp=1/1", c_sop, c_eop); end
        n_chk++; if (frame_cnt !== 8'(exp_fcnt)) begin n_fail++; $display("FAIL full_fcnt got=%0d exp=%0d", frame_cnt, exp_fcnt); end
        n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL full_missing got=%0d pending exp=0", sb.size()); end
    endtask

    task automatic test_crop();
        set_win(2, 3, 1, 2);
        clr_counts();
        send_frame(8, 4, 1, -1, -1, -1);
        exp_fcnt++;
        n_chk++; if (c_vld != 6) begin n_fail++; $display("FAIL crop_vld got=%0d exp=6", c_vld); end
        n_chk++; if (c_sop != 1 || c_eop != 1 || c_ferr != 0) begin n_fail++; $display("FAIL crop_flags sop=%0d eop=%0d ferr=%0d exp=1/1/0", c_sop, c_eop, c_ferr); end
        n_chk++; if (frame_cnt !== 8'(exp_fcnt)) begin n_fail++; $display("FAIL crop_fcnt got=%0d exp=%0d", frame_cnt, exp_fcnt); end
        set_win(0, 0, 0, 4);
        clr_counts();
        send_frame(8, 4, 1, -1, -1, -1);
        n_chk++; if (c_vld != 0 || c_ferr != 0) begin n_fail++; $display("FAIL zero_width vld=%0d ferr=%0d exp=0/0", c_vld, c_ferr); end
        n_chk++; if (frame_cnt !== 8'(exp_fcnt)) begin n_fail++; $display("FAIL zero_width_fcnt got=%0d exp=%0d", frame_cnt, exp_fcnt); end
    endtask

    task automatic test_skip();
        set_win(0, 8, 0, 4);
        skip_n = 4'd2;
        clr_counts();
        for (int i = 0; i < 7; i++) begin
            send_frame(8, 4, (i % 3) == 0, -1, -1, (i == 0) ? 0 : -1);
            if (i == 0) skip_n = 4'd2;
        end
        exp_fcnt += 3;
        n_chk++; if (c_vld != 96) begin n_fail++; $display("FAIL skip_vld got=%0d exp=96", c_vld); end
        n_chk++; if (c_eop != 3 || c_sop != 3) begin n_fail++; $display("FAIL skip_flags sop=%0d eop=%0d exp=3/3", c_sop, c_eop); end
        n_chk++; if (frame_cnt !== 8'(exp_fcnt)) begin n_fail++; $display("FAIL skip_fcnt got=%0d exp=%0d", frame_cnt, exp_fcnt); end
        skip_n = 4'd0;
        cap_en = 1'b0; tick(2);
        cap_en = 1'b1; tick(2);
    endtask

    task automatic test_overrun();
        set_win(0, 8, 0, 6);
        clr_counts();
        send_frame(8, 4, 1, -1, -1, -1);
        n_chk++; if (c_vld != 32 || c_sop != 1 || c_eop != 0) begin n_fail++; $display("FAIL overrun_flags vld=%0d sop=%0d eop=%0d exp=32/1/0", c_vld, c_sop, c_eop); end
        n_chk++; if (c_ferr != 1) begin n_fail++; $display("FAIL overrun_ferr got=%0d exp=1", c_ferr); end
        n_chk++; if (frame_cnt !== 8'(exp_fcnt)) begin n_fail++; $display("FAIL overrun_fcnt got=%0d exp=%0d", frame_cnt, exp_fcnt); end
    endtask

    task automatic test_line_err();
        set_win(0, 8, 0, 4);
        clr_counts();
        send_frame(8, 4, 1, 1, -1, -1);
        exp_fcnt++;
        n_chk++; if (c_vld != 26) begin n_fail++; $display("FAIL lerr_vld got=%0d exp=26", c_vld); end
        n_chk++; if (c_lerr != 1) begin n_fail++; $display("FAIL lerr_pulses got=%0d exp=1", c_lerr); end
        n_chk++; if (frame_cnt !== 8'(exp_fcnt) || c_ferr != 0) begin n_fail++; $display("FAIL lerr_fcnt got=%0d/%0d exp=%0d/0", frame_cnt, c_ferr, exp_fcnt); end
    endtask

    task automatic test_cap_en();
        set_win(0, 8, 0, 4);
        clr_counts();
        send_frame(8, 4, 1, -1, 1, -1);
        n_chk++; if (c_vld != 8 || c_eop != 0) begin n_fail++; $display("FAIL drop_vld got=%0d/%0d exp=8/0", c_vld, c_eop); end
        n_chk++; if (c_ferr != 0) begin n_fail++; $display("FAIL drop_ferr got=%0d exp=0", c_ferr); end
        n_chk++; if (frame_cnt !== 8'(exp_fcnt)) begin n_fail++; $display("FAIL drop_fcnt got=%0d exp=%0d", frame_cnt, exp_fcnt); end
        clr_counts();
        send_frame(8, 4, 1, -1, -1, -1);
        exp_fcnt++;
        n_chk++; if (c_vld != 32 || c_sop != 1 || c_eop != 1) begin n_fail++; $display("FAIL rearm got=%0d/%0d/%0d exp=32/1/1", c_vld, c_sop, c_eop); end
        n_chk++; if (frame_cnt !== 8'(exp_fcnt)) begin n_fail++; $display("FAIL rearm_fcnt got=%0d exp=%0d", frame_cnt, exp_fcnt); end
        n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL final_missing got=%0d pending exp=0", sb.size()); end
    endtask

    initial begin
        clr_counts();
        test_reset();
        test_crop();
        test_skip();
        test_overrun();
        test_line_err();
        test_cap_en();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dvp_capture_win.md
Name: dvp_capture_win

Overview:
- Parametrised successor to the camera capture stage.
- Runs in the camera pixel-clock domain. Assembles DVP bytes into pixels and crops a runtime-programmable window.
- Decimates frames by a runtime skip count. Emits a sop/eop-framed pixel stream to the image-process / SDRAM write path.
- Flags truncated frames and malformed lines.

Parameters:
- DATA_W, 8, DVP data bus width.
- BYTES_PER_PIX, 2, bus beats per pixel (1 or 2); first beat is the MS part.
- X_W, 12, width of column counters and window x ports.
- Y_W, 12, width of line counters and window y ports.
- VS_POL, 1, vsync level that marks vertical blanking (1 = active-high pulse).
- FCNT_W, 8, width of captured-frame counter.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous active-high reset.
- cap_en  in  1  capture enable (from sensor config done).
- cmos_vsync  in  1  sensor vsync.
- cmos_href  in  1  sensor line valid.
- cmos_din  in  DATA_W  sensor data.
- win_x0  in  X_W  first captured column.
- win_w  in  X_W  captured width in pixels (0 = disabled).
- win_y0  in  Y_W  first captured line.
- win_h  in  Y_W  captured height in lines.
- skip_n  in  4  frames dropped after each captured frame.
- pixel  out  DATA_W*BYTES_PER_PIX  assembled pixel.
- pixel_vld  out  1  pixel strobe.
- pixel_sop  out  1  first window pixel, qualified by pixel_vld.
- pixel_eop  out  1  last window pixel, qualified by pixel_vld.
- frame_cnt  out  FCNT_W  captured frames (count of eops), wraps.
- frame_err  out  1  one-cycle pulse: frame ended before eop.
- line_err  out  1  one-cycle pulse: href fell mid-pixel.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; counters 0.
- Input registration: cmos_vsync, cmos_href and cmos_din are registered once. Edges are detected on the registered copies.
- Frame start (FS) is the vsync transition from VS_POL to !VS_POL.
- States:
  - IDLE: leave on cap_en=1 -> WAIT_FS.
  - WAIT_FS: on FS -> ACTIVE. win_* and skip_n are latched at this FS and hold for the whole frame.
  - ACTIVE: capture. On vsync returning to VS_POL:
    - if skip_n_latched=0 -> WAIT_FS;
    - else -> SKIP with skip counter = skip_n_latched.
  - SKIP: each FS decrements the counter. The FS that finds the counter at 0 -> ACTIVE, latching window and skip_n.
  - cap_en=0 in any state -> IDLE next cycle. A partial frame ends with no eop and no frame_err.
- Byte assembly:
  - Beat counter runs 0..BYTES_PER_PIX-1 while registered href=1, and clears when href=0.
  - A pixel completes on the final beat.
  - href falling with beat counter != 0 -> line_err pulse; the partial pixel is discarded.
- Counters:
  - col increments per completed pixel and clears on href fall.
  - line increments on each href fall within the frame and clears at FS.
- Window test: in = (col - win_x0) < win_w AND (line - win_y0) < win_h. Unsigned compare, X_W/Y_W bits, done without wrap into negative values.
- Output flags:
  - pixel_vld = completed pixel AND in AND state ACTIVE.
  - sop on col=win_x0 and line=win_y0.
  - eop on col=win_x0+win_w-1 and line=win_y0+win_h-1.
- Latency: 2 clk from the sampling edge of a pixel's final beat to pixel_vld.
- Window beyond sensor frame: no eop is produced. At the vsync-to-VS_POL end of an ACTIVE frame with sop seen and eop not seen -> frame_err pulse.
- win_w=0 or win_h=0: no pixel_vld at all, and no frame_err.
- frame_cnt increments on each pixel_vld & pixel_eop and wraps at 2^FCNT_W.
- Simultaneous FS and cap_en fall: cap_en fall wins.

Optional Feature:
- Macro: DVP_TEST_PATTERN_EN.
- Defined:
  - adds input tp_sel (1 bit);
  - when tp_sel=1, pixel is replaced by an 8-bar colour pattern selected by col[X_W-1 -: 3] of the window-relative column. Bars are full-scale RGB565 in this order: white, yellow, cyan, green, magenta, red, blue, black. Replication applies when DATA_W*BYTES_PER_PIX != 16.
  - Timing and flags are unchanged.
- Undefined: no tp_sel port; pixel is always sensor data.

Decomposition:
- Shared package (dvp_pkg): state encoding, VS_POL/FS edge definition, and the colour-bar constant table.
- Natural sub-module: dvp_beat_pack. It registers the inputs, assembles beats, and produces pixel/done/col/line_end/line_err. The window, skip FSM and flags stay in the top.

Test Plan:
- Reset: rst=1 for 3 clk, then cap_en=1, frame 8x4, BYTES_PER_PIX=2, full window 0/8/0/4 -> exactly 32 pixel_vld; sop on the first, eop on the 32nd; frame_cnt=1.
- Crop window x0=2, w=3, y0=1, h=2 on an 8x4 ramp source -> 6 pixels = cols 2..4 of lines 1..2. sop = pixel(2,1), eop = pixel(4,2). pixel_vld is 2 clk after the final beat.
- skip_n=2 over 7 frames -> frames 1, 4, 7 captured; frame_cnt=3. Change skip_n mid-frame -> no effect until the next latch.
- Window h=6 on a 4-line frame -> sop seen, no eop, frame_err pulse at the vsync rise; frame_cnt unchanged.
- href high for 5 beats at BYTES_PER_PIX=2 -> 2 pixels then a line_err pulse; the next line captures normally.
- cap_en dropped mid-frame, then re-raised mid-frame -> no output until the next FS, then a clean sop.
